// File: rtl/businv_pkg.sv
// Shared constants, toggle-count type and popcount helper for the partitioned bus-invert encoder.
package businv_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NPART = 2;
  localparam int POP_MAX   = 64;

  typedef logic [7:0] tcnt_t;

  // Callers zero-pad narrower vectors up to POP_MAX bits.
  function automatic tcnt_t popcount(input logic [POP_MAX-1:0] v);
    tcnt_t c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) c = c + tcnt_t'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/businv_lane.sv
// One invert partition: Hamming distance to the current bus value and the invert decision.
// Exposes the raw distance only when BUSINV_STATS_EN is defined.
module businv_lane
  import businv_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          en,
  input  logic [PW-1:0] din_p,
  input  logic [PW-1:0] bus_p,
  input  logic          inv_p,
  output logic [PW-1:0] bus_nxt,
  output logic          inv_nxt
`ifdef BUSINV_STATS_EN
  ,
  output tcnt_t         dist
`endif
);

  localparam tcnt_t HALF = tcnt_t'(PW / 2);

  logic [POP_MAX-1:0] diff;
  tcnt_t              d;

  always_comb begin
    diff           = '0;
    diff[PW-1:0]   = din_p ^ bus_p;
    d              = popcount(diff);
    inv_nxt        = 1'b0;
    // A tie keeps the previous polarity so the invert line does not toggle needlessly.
    if (en) begin
      if (d > HALF)       inv_nxt = 1'b1;
      else if (d == HALF) inv_nxt = inv_p;
    end
    bus_nxt = din_p ^ {PW{inv_nxt}};
  end

`ifdef BUSINV_STATS_EN
  assign dist = d;
`endif

endmodule

// File: rtl/businv_part_enc.sv
// Partitioned bus-invert encoder with registered outputs and a decoded loop-back word.
// Define BUSINV_STATS_EN to add the toggle/saved-toggle statistics counters.
module businv_part_enc
  import businv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NPART = DEF_NPART
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] bus_out,
  output logic [NPART-1:0] inv_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
`ifdef BUSINV_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      trans_cnt,
  output logic [15:0]      saved_cnt
`endif
);

  localparam int PW = WIDTH / NPART;

  logic             accept;
  logic             take;
  logic [WIDTH-1:0] bus_nxt;
  logic [NPART-1:0] inv_nxt;
  logic [WIDTH-1:0] inv_exp;
`ifdef BUSINV_STATS_EN
  tcnt_t            dist [NPART];
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;

  for (genvar p = 0; p < NPART; p++) begin : g_lane
    businv_lane #(.PW(PW)) u_lane (
      .en      (en),
      .din_p   (din[p*PW +: PW]),
      .bus_p   (bus_out[p*PW +: PW]),
      .inv_p   (inv_out[p]),
      .bus_nxt (bus_nxt[p*PW +: PW]),
      .inv_nxt (inv_nxt[p])
`ifdef BUSINV_STATS_EN
      ,
      .dist    (dist[p])
`endif
    );
    assign inv_exp[p*PW +: PW] = {PW{inv_out[p]}};
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      bus_out    <= '0;
      inv_out    <= '0;
      out_valid  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (accept) begin
        bus_out <= bus_nxt;
        inv_out <= inv_nxt;
      end
      if (accept)    out_valid <= 1'b1;
      else if (take) out_valid <= 1'b0;
      if (take) dout <= bus_out ^ inv_exp;
      dout_valid <= take;
    end
  end

`ifdef BUSINV_STATS_EN
  logic [POP_MAX-1:0] bus_diff;
  logic [POP_MAX-1:0] inv_diff;
  logic [15:0]        tog;
  logic [15:0]        sum_d;
  logic [16:0]        trans_sum;
  logic signed [17:0] saved_sum;
  logic [15:0]        trans_new;
  logic [15:0]        saved_new;

  // Saved count can step down when a polarity flip costs more than it saves; clamp at both ends.
  always_comb begin
    bus_diff            = '0;
    bus_diff[WIDTH-1:0] = bus_nxt ^ bus_out;
    inv_diff            = '0;
    inv_diff[NPART-1:0] = inv_nxt ^ inv_out;
    tog                 = 16'(popcount(bus_diff)) + 16'(popcount(inv_diff));
    sum_d               = '0;
    for (int p = 0; p < NPART; p++) sum_d = sum_d + 16'(dist[p]);
    trans_sum = {1'b0, trans_cnt} + {1'b0, tog};
    trans_new = trans_sum[16] ? 16'hFFFF : trans_sum[15:0];
    saved_sum = $signed({2'b00, saved_cnt}) + $signed({2'b00, sum_d}) - $signed({2'b00, tog});
    if (saved_sum < 18'sd0)          saved_new = 16'h0000;
    else if (saved_sum > 18'sd65535) saved_new = 16'hFFFF;
    else                             saved_new = saved_sum[15:0];
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      trans_cnt <= '0;
      saved_cnt <= '0;
    end else if (stat_clr) begin
      trans_cnt <= '0;
      saved_cnt <= '0;
    end else if (accept) begin
      trans_cnt <= trans_new;
      saved_cnt <= saved_new;
    end
  end
`endif

endmodule

// File: tb/tb_businv_part_enc.sv
// Scoreboard bench for businv_part_enc (WIDTH=16, NPART=2); BUSINV_STATS_EN enables counter checks.
module tb_businv_part_enc;

  localparam int W  = 16;
  localparam int NP = 2;
  localparam int PW = W / NP;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  bus_out;
  logic [NP-1:0] inv_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  dout;
  logic          dout_valid;
`ifdef BUSINV_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   trans_cnt;
  logic [15:0]   saved_cnt;
  int            m_trans;
  int            m_saved;
`endif

  businv_part_enc #(.WIDTH(W), .NPART(NP)) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .bus_out    (bus_out),
    .inv_out    (inv_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
    .dout_valid (dout_valid)
`ifdef BUSINV_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .trans_cnt  (trans_cnt),
    .saved_cnt  (saved_cnt)
`endif
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [W-1:0]  bus;
    logic [NP-1:0] inv;
    logic [W-1:0]  raw;
  } enc_t;

  enc_t          enc_q[$];
  logic [W-1:0]  dout_q[$];
  logic [W-1:0]  m_bus;
  logic [NP-1:0] m_inv;
  logic          m_pend;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: count differing bits per partition and choose polarity by majority.
  task automatic m_encode(input logic [W-1:0] d, input logic e,
                          output logic [W-1:0] nb, output logic [NP-1:0] ni,
                          output int sumd, output int tog);
    sumd = 0;
    tog  = 0;
    nb   = '0;
    ni   = '0;
    for (int p = 0; p < NP; p++) begin
      int dd;
      dd = 0;
      for (int b = 0; b < PW; b++) if (d[p*PW+b] != m_bus[p*PW+b]) dd++;
      sumd += dd;
      if (!e)              ni[p] = 1'b0;
      else if (2*dd > PW)  ni[p] = 1'b1;
      else if (2*dd < PW)  ni[p] = 1'b0;
      else                 ni[p] = m_inv[p];
      for (int b = 0; b < PW; b++) nb[p*PW+b] = d[p*PW+b] ^ ni[p];
    end
    for (int b = 0; b < W; b++)  if (nb[b] != m_bus[b]) tog++;
    for (int p = 0; p < NP; p++) if (ni[p] != m_inv[p]) tog++;
  endtask

  task automatic model_reset();
    m_bus  = '0;
    m_inv  = '0;
    m_pend = 1'b0;
    enc_q.delete();
    dout_q.delete();
`ifdef BUSINV_STATS_EN
    m_trans = 0;
    m_saved = 0;
`endif
  endtask

  task automatic model_edge();
    logic          acc;
    logic          tk;
    logic [W-1:0]  nb;
    logic [NP-1:0] ni;
    int            sumd;
    int            tog;
    acc = in_valid && (!m_pend || out_ready);
    tk  = m_pend && out_ready;
    sumd = 0;
    tog  = 0;
    if (acc) begin
      m_encode(din, en, nb, ni, sumd, tog);
      enc_q.push_back('{bus: nb, inv: ni, raw: din});
      m_bus = nb;
      m_inv = ni;
    end
`ifdef BUSINV_STATS_EN
    if (stat_clr) begin
      m_trans = 0;
      m_saved = 0;
    end else if (acc) begin
      m_trans = (m_trans + tog > 65535) ? 65535 : m_trans + tog;
      m_saved = m_saved + sumd - tog;
      if (m_saved < 0) m_saved = 0;
      if (m_saved > 65535) m_saved = 65535;
    end
`endif
    if (acc)     m_pend = 1'b1;
    else if (tk) m_pend = 1'b0;
  endtask

  task automatic step(input logic v, input logic e, input logic [W-1:0] d,
                      input logic ordy, input logic clr);
    in_valid  = v;
    en        = e;
    din       = d;
    out_ready = ordy;
`ifdef BUSINV_STATS_EN
    stat_clr  = clr;
`else
    if (clr) begin end
`endif
    @(posedge ck);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #2;
    chk("rst_bus_out", 32'(bus_out), 32'h0);
    chk("rst_inv_out", 32'(inv_out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
`ifdef BUSINV_STATS_EN
    chk("rst_trans_cnt", 32'(trans_cnt), 32'h0);
    chk("rst_saved_cnt", 32'(saved_cnt), 32'h0);
`endif
    repeat (2) @(posedge ck);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("in_ready_after_release", 32'(in_ready), 32'h1);
  endtask

  // Monitor: at each falling edge, check handshakes against the model and pop presented words.
  always @(negedge ck) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(m_pend));
      chk("in_ready", 32'(in_ready), 32'(!m_pend || out_ready));
      if (dout_valid) begin
        if (dout_q.size() == 0) chk("dout_valid_unexpected", 32'h1, 32'h0);
        else chk("dout", 32'(dout), 32'(dout_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (enc_q.size() == 0) chk("take_without_word", 32'h1, 32'h0);
        else begin
          enc_t e;
          e = enc_q.pop_front();
          chk("bus_out", 32'(bus_out), 32'(e.bus));
          chk("inv_out", 32'(inv_out), 32'(e.inv));
          dout_q.push_back(e.raw);
        end
      end
`ifdef BUSINV_STATS_EN
      chk("trans_cnt", 32'(trans_cnt), 32'(m_trans));
      chk("saved_cnt", 32'(saved_cnt), 32'(m_saved));
`endif
    end
  end

  initial begin
    logic [W-1:0] held;
    model_reset();
    do_reset();

    // Majority invert on the low partition.
    step(1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0);
    chk("d035_bus", 32'(bus_out), 32'h0000);
    chk("d035_inv", 32'(inv_out), 32'h1);
    step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    chk("d035_dout_valid", 32'(dout_valid), 32'h1);
    chk("d035_dout", 32'(dout), 32'h00FF);
`ifdef BUSINV_STATS_EN
    chk("d040_trans", 32'(trans_cnt), 32'd1);
    chk("d040_saved", 32'(saved_cnt), 32'd7);
    step(1'b1, 1'b1, 16'h3C5A, 1'b1, 1'b1);
    chk("d040_clr_trans", 32'(trans_cnt), 32'd0);
    chk("d040_clr_saved", 32'(saved_cnt), 32'd0);
`endif

    // Tie keeps polarity, both from 0 and from 1.
    do_reset();
    step(1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);
    chk("d036_tie0_bus", 32'(bus_out), 32'h000F);
    chk("d036_tie0_inv", 32'(inv_out), 32'h0);
    do_reset();
    step(1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);
    chk("d036_tie1_inv0", 32'(inv_out[0]), 32'h1);
    chk("d036_tie1_bus", 32'(bus_out), 32'h00F0);

    // Backpressure stall.
    do_reset();
    step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    held = bus_out;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
      chk("d037_in_ready", 32'(in_ready), 32'h0);
      chk("d037_bus_hold", 32'(bus_out), 32'(held));
    end
    step(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0);
    chk("d037_out_valid", 32'(out_valid), 32'h1);
    chk("d037_second_bus", 32'(bus_out), 32'(m_bus));
    step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Bypass.
    do_reset();
    step(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    chk("d038_bus", 32'(bus_out), 32'hFFFF);
    chk("d038_inv", 32'(inv_out), 32'h0);

    // Reset with a pending word.
    do_reset();
    step(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
    chk("d039_pending", 32'(out_valid), 32'h1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      chk("d039_no_dout_valid", 32'(dout_valid), 32'h0);
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           16'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("end_enc_q_empty", 32'(enc_q.size()), 32'h0);
    chk("end_dout_q_empty", 32'(dout_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
